// File: rtl/qsfp_i2c_target.sv
// QSFP management-interface I2C target at 7-bit address DEV_ADDR.
// Conditions the raw SCL/SDA pins, detects START/STOP, and runs a byte-level
// protocol engine that backs the module memory map with an external byte RAM.
// Byte 127 doubles as the upper-page select register.
module qsfp_i2c_target #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic [15:0] mem_addr,
  output logic        mem_rden,
  input  logic [7:0]  mem_rdata,
  output logic        mem_wren,
  output logic [7:0]  mem_wdata,
  output logic [7:0]  page_sel,
  output logic        busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_WR_BYTE  = 3'd3;
  localparam logic [2:0] S_WR_ACK   = 3'd4;
  localparam logic [2:0] S_RD_BYTE  = 3'd5;
  localparam logic [2:0] S_RD_ACK   = 3'd6;
  localparam logic [2:0] S_IGNORE   = 3'd7;

  localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);

  // Pin conditioning state: synchronizers, stability filters, previous values.
  logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [3:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic       scl_p_q, scl_p_d, sda_p_q, sda_p_d;

  // Protocol state.
  logic [2:0]  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        first_byte_q, first_byte_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  page_sel_q, page_sel_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        mem_rden_q, mem_rden_d;
  logic        mem_wren_q, mem_wren_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        rd_load_q, rd_load_d;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  // Synchronize both pins, then only follow a pin after FILTER_LEN agreeing samples.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    scl_sync_d = {scl_sync_q[0], scl_i};
    sda_sync_d = {sda_sync_q[0], sda_i};
    scl_f_d    = scl_f_q;
    sda_f_d    = sda_f_q;
    scl_cnt_d  = 4'd0;
    sda_cnt_d  = 4'd0;
    scl_p_d    = scl_f_q;
    sda_p_d    = sda_f_q;
    if (scl_sync_q[1] != scl_f_q) begin
      if (scl_cnt_q == FILT_LAST) scl_f_d = scl_sync_q[1];
      else                        scl_cnt_d = scl_cnt_q + 4'd1;
    end
    if (sda_sync_q[1] != sda_f_q) begin
      if (sda_cnt_q == FILT_LAST) sda_f_d = sda_sync_q[1];
      else                        sda_cnt_d = sda_cnt_q + 4'd1;
    end
  end

  assign scl_rise  = scl_f_q & ~scl_p_q;
  assign scl_fall  = ~scl_f_q & scl_p_q;
  assign start_det = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop_det  = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;
  assign rx_byte   = {shift_q[6:0], sda_f_q};

  // Protocol engine: bits sampled on SCL rise, SDA drive changed on SCL fall.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    first_byte_d = first_byte_q;
    ptr_d        = ptr_q;
    page_sel_d   = page_sel_q;
    sda_oe_d     = sda_oe_q;
    busy_d       = busy_q;
    mem_addr_d   = mem_addr_q;
    mem_rden_d   = 1'b0;
    mem_wren_d   = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    rd_load_d    = mem_rden_q;

    // Read data arrives the cycle after the strobe; it becomes the next TX byte.
    if (rd_load_q) shift_d = mem_rdata;

    if (start_det) begin
      state_d   = S_ADDR;
      busy_d    = 1'b1;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 3'd0;
    end else if (stop_det) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: if (scl_rise) begin
          shift_d = rx_byte;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            state_d   = (rx_byte[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_IGNORE;
          end else bit_cnt_d = bit_cnt_q + 3'd1;
        end
        S_ADDR_ACK: begin
          if (scl_fall) sda_oe_d = 1'b1;
          if (scl_rise) begin
            bit_cnt_d = 3'd0;
            if (shift_q[0]) begin
              mem_rden_d = 1'b1;
              state_d    = S_RD_BYTE;
            end else begin
              first_byte_d = 1'b1;
              state_d      = S_WR_BYTE;
            end
          end
        end
        S_WR_BYTE: begin
          if (scl_fall) sda_oe_d = 1'b0;
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = 3'd0;
              state_d   = S_WR_ACK;
              if (first_byte_q) begin
                ptr_d        = rx_byte;
                first_byte_d = 1'b0;
              end else begin
                mem_wren_d  = 1'b1;
                mem_addr_d  = {(ptr_q[7] ? page_sel_q : 8'h00), ptr_q};
                mem_wdata_d = rx_byte;
                if (ptr_q == 8'd127) page_sel_d = rx_byte;
                ptr_d = ptr_q + 8'd1;
              end
            end else bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        S_WR_ACK: begin
          if (scl_fall) sda_oe_d = 1'b1;
          if (scl_rise) state_d = S_WR_BYTE;
        end
        S_RD_BYTE: begin
          if (scl_fall) begin
            sda_oe_d = ~shift_q[7];
            shift_d  = {shift_q[6:0], 1'b0};
          end
          if (scl_rise) begin
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = 3'd0;
              state_d   = S_RD_ACK;
            end else bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        S_RD_ACK: begin
          if (scl_fall) sda_oe_d = 1'b0;
          if (scl_rise) begin
            if (!sda_f_q) begin
              ptr_d      = ptr_q + 8'd1;
              mem_rden_d = 1'b1;
              state_d    = S_RD_BYTE;
            end else state_d = S_IGNORE;
          end
        end
        default: if (scl_fall) sda_oe_d = 1'b0;
      endcase
    end

    // A read strobe always addresses the pointer value it leaves behind.
    if (mem_rden_d) mem_addr_d = {(ptr_d[7] ? page_sel_q : 8'h00), ptr_d};
  end

  // Pin conditioning registers; an idle bus is high on both lines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_cnt_q  <= 4'd0;
      sda_cnt_q  <= 4'd0;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_p_q    <= scl_p_d;
      sda_p_q    <= sda_p_d;
    end
  end

  // Protocol registers; reset releases SDA and cancels any pending strobe at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      first_byte_q <= 1'b0;
      ptr_q        <= 8'h00;
      page_sel_q   <= 8'h00;
      sda_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      mem_addr_q   <= 16'h0000;
      mem_rden_q   <= 1'b0;
      mem_wren_q   <= 1'b0;
      mem_wdata_q  <= 8'h00;
      rd_load_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      first_byte_q <= first_byte_d;
      ptr_q        <= ptr_d;
      page_sel_q   <= page_sel_d;
      sda_oe_q     <= sda_oe_d;
      busy_q       <= busy_d;
      mem_addr_q   <= mem_addr_d;
      mem_rden_q   <= mem_rden_d;
      mem_wren_q   <= mem_wren_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_load_q    <= rd_load_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rden  = mem_rden_q;
  assign mem_wren  = mem_wren_q;
  assign mem_wdata = mem_wdata_q;
  assign page_sel  = page_sel_q;
  assign busy      = busy_q;

endmodule
